// File: rtl/seg_display_scan.sv
// Four-digit multiplexed 7-segment scanner with frame-synchronous update.
// Shows a 12-bit word as three hex digits. The leftmost digit is always blank.
module seg_display_scan #(
    parameter int REFRESH_DIV = 4,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] data_in,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        updated
);

    localparam logic [15:0] PRESC_TOP = 16'(REFRESH_DIV - 1);

    logic [15:0] presc;
    logic [1:0]  idx;
    logic        tick;
    logic        frame_start;
    logic [11:0] shadow;
    logic [11:0] display;
    logic        pending;
    logic [3:0]  an_nxt;
    logic [3:0]  nib;
    logic        blank;
    logic [6:0]  glyph;

    assign tick        = (presc == PRESC_TOP);
    assign frame_start = tick && (idx == 2'd3);

    function automatic logic [6:0] font(input logic [3:0] n);
        logic [6:0] f;
        unique case (n)
            4'h0: f = 7'b0000001;
            4'h1: f = 7'b1001111;
            4'h2: f = 7'b0010010;
            4'h3: f = 7'b0000110;
            4'h4: f = 7'b1001100;
            4'h5: f = 7'b0100100;
            4'h6: f = 7'b0100000;
            4'h7: f = 7'b0001111;
            4'h8: f = 7'b0000000;
            4'h9: f = 7'b0000100;
            4'hA: f = 7'b0001000;
            4'hB: f = 7'b1100000;
            4'hC: f = 7'b0110001;
            4'hD: f = 7'b1000010;
            4'hE: f = 7'b0110000;
            4'hF: f = 7'b0111000;
        endcase
        return f;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= tick ? '0 : presc + 16'd1;
            if (tick) idx <= idx + 2'd1;
        end
    end

    // Display only moves at frame start, so a frame never mixes two values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            display <= '0;
            pending <= 1'b0;
            updated <= 1'b0;
        end else begin
            if (load) shadow <= data_in;
            if (frame_start && pending) display <= shadow;
            updated <= frame_start && pending;
            if (load)             pending <= 1'b1;
            else if (frame_start) pending <= 1'b0;
        end
    end

    always_comb begin
        an_nxt = 4'b1111;
        nib    = display[3:0];
        blank  = 1'b1;
        unique case (idx)
            2'd0: begin
                an_nxt = 4'b1110;
                nib    = display[3:0];
                blank  = 1'b0;
            end
            2'd1: begin
                an_nxt = 4'b1101;
                nib    = display[7:4];
                blank  = BLANK_LZ && (display[11:4] == 8'h00);
            end
            2'd2: begin
                an_nxt = 4'b1011;
                nib    = display[11:8];
                blank  = BLANK_LZ && (display[11:8] == 4'h0);
            end
            2'd3: begin
                an_nxt = 4'b0111;
                blank  = 1'b1;
            end
        endcase
        glyph = font(nib);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an  <= an_nxt;
            seg <= blank ? 7'b1111111 : glyph;
        end
    end

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan: scan order, font, blanking,
// frame-synchronous update, last-load-wins and async reset.
module tb_seg_display_scan;

    logic        clk;
    logic        rst_n;
    logic [11:0] data_in;
    logic        load;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        updated;
    logic [3:0]  an_nlz;
    logic [6:0]  seg_nlz;
    logic        upd_nlz;

    int n_chk = 0;
    int n_err = 0;
    int cyc;
    int upd_cnt = 0;

    seg_display_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load),
        .an(an), .seg(seg), .updated(updated)
    );

    seg_display_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_nlz (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load),
        .an(an_nlz), .seg(seg_nlz), .updated(upd_nlz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge count since reset release: after edge k, cyc == k.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (updated) upd_cnt <= upd_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic seg_of(input string tag, input bit nlz,
                          input logic [3:0] pat, input logic [6:0] exp);
        for (int i = 0; i < 40; i++) begin
            if ((nlz ? an_nlz : an) == pat) break;
            @(negedge clk);
        end
        check({tag, "_an"}, 16'(nlz ? an_nlz : an), 16'(pat));
        check(tag, 16'(nlz ? seg_nlz : seg), 16'(exp));
    endtask

    logic [3:0] an_pat [4];
    logic [6:0] seg_idle [4];

    initial begin
        an_pat[0] = 4'b1110; an_pat[1] = 4'b1101;
        an_pat[2] = 4'b1011; an_pat[3] = 4'b0111;
        seg_idle[0] = 7'b0000001; seg_idle[1] = 7'b1111111;
        seg_idle[2] = 7'b1111111; seg_idle[3] = 7'b1111111;
        rst_n   = 1'b0;
        load    = 1'b0;
        data_in = '0;
        repeat (3) @(negedge clk);
        check("rst_an", 16'(an), 16'hF);
        check("rst_seg", 16'(seg), 16'h7F);
        check("rst_upd", 16'(updated), 16'h0);
        rst_n = 1'b1;

        // Idle scan: slot changes every 4 edges, digit 0 shows '0'.
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check($sformatf("idle_an_%0d", k), 16'(an),
                  16'(an_pat[((k - 1) / 4) % 4]));
            check($sformatf("idle_seg_%0d", k), 16'(seg),
                  16'(seg_idle[((k - 1) / 4) % 4]));
        end
        check("idle_upd_cnt", 16'(upd_cnt), 16'd0);

        // Mid-frame load of 3A5; display waits for frame start at edge 32.
        data_in = 12'h3A5;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_cyc(25);
        check("tear_an", 16'(an), 16'hB);
        check("tear_seg", 16'(seg), 16'h7F);
        wait_cyc(31);
        check("a_upd_pre", 16'(updated), 16'h0);
        @(negedge clk);
        check("a_upd", 16'(updated), 16'h1);
        @(negedge clk);
        check("a_upd_post", 16'(updated), 16'h0);
        seg_of("a_d0", 1'b0, 4'b1110, 7'b0100100);
        seg_of("a_d1", 1'b0, 4'b1101, 7'b0001000);
        seg_of("a_d2", 1'b0, 4'b1011, 7'b0000110);

        // Three loads in one frame; last wins, one pulse at edge 64.
        wait_cyc(49);
        data_in = 12'h111;
        load    = 1'b1;
        @(negedge clk);
        data_in = 12'h222;
        @(negedge clk);
        data_in = 12'h00F;
        @(negedge clk);
        load = 1'b0;
        wait_cyc(63);
        check("b_upd_pre", 16'(updated), 16'h0);
        @(negedge clk);
        check("b_upd", 16'(updated), 16'h1);
        @(negedge clk);
        check("b_upd_post", 16'(updated), 16'h0);
        seg_of("b_d0", 1'b0, 4'b1110, 7'b0111000);
        seg_of("b_d1", 1'b0, 4'b1101, 7'b1111111);
        seg_of("b_d2", 1'b0, 4'b1011, 7'b1111111);
        check("b_upd_cnt", 16'(upd_cnt), 16'd2);

        // 123 pending, 0B0 loaded on frame-start edge 96.
        wait_cyc(84);
        data_in = 12'h123;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_cyc(95);
        data_in = 12'h0B0;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("c_upd1", 16'(updated), 16'h1);
        seg_of("c_d0", 1'b0, 4'b1110, 7'b0000110);
        seg_of("c_d1", 1'b0, 4'b1101, 7'b0010010);
        seg_of("c_d2", 1'b0, 4'b1011, 7'b1001111);
        wait_cyc(111);
        check("c_upd_gap", 16'(updated), 16'h0);
        @(negedge clk);
        check("c_upd2", 16'(updated), 16'h1);
        seg_of("c_e0", 1'b0, 4'b1110, 7'b0000001);
        seg_of("c_e1", 1'b0, 4'b1101, 7'b1100000);
        seg_of("c_e2", 1'b0, 4'b1011, 7'b1111111);
        check("c_upd_cnt", 16'(upd_cnt), 16'd4);

        // Reset with data pending, mid-slot.
        wait_cyc(130);
        data_in = 12'h456;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_cyc(134);
        rst_n = 1'b0;
        #1;
        check("r_an", 16'(an), 16'hF);
        check("r_seg", 16'(seg), 16'h7F);
        check("r_upd", 16'(updated), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(40);
        check("r_upd_cnt", 16'(upd_cnt), 16'd4);
        seg_of("r_d0", 1'b0, 4'b1110, 7'b0000001);
        seg_of("r_d1", 1'b0, 4'b1101, 7'b1111111);
        seg_of("r_d2", 1'b0, 4'b1011, 7'b1111111);

        // No blanking instance shows 007 with explicit zeros.
        wait_cyc(52);
        data_in = 12'h007;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_cyc(64);
        check("n_upd", 16'(upd_nlz), 16'h1);
        seg_of("n_d0", 1'b1, 4'b1110, 7'b0001111);
        seg_of("n_d1", 1'b1, 4'b1101, 7'b0000001);
        seg_of("n_d2", 1'b1, 4'b1011, 7'b0000001);
        seg_of("n_lz1", 1'b0, 4'b1110, 7'b0001111);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
